// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

   // Loader phases, in the order an image is consumed.
   typedef enum logic [2:0] {
      HDR_HI = 3'd0,
      HDR_LO = 3'd1,
      DATA   = 3'd2,
      CSUM   = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } state_t;

   localparam int WORD_BYTES         = 4;
   localparam int CSUM_W             = 8;
   localparam int DEF_MAX_WORDS      = 256;
   localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/program_loader_word_asm.sv
// Big-endian word assembler with running payload checksum.
// o_word is the word including the byte currently presented, so the parent
// can capture a finished word on the same edge that accepts its last byte.
module loader_word_asm
   import program_loader_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_clear,
   input  logic                    i_byte_en,
   input  logic [7:0]              i_byte,
   output logic [8*WORD_BYTES-1:0] o_word,
   output logic                    o_word_last,
   output logic [CSUM_W-1:0]       o_csum
);

   localparam int IDX_W = $clog2(WORD_BYTES);

   logic [8*WORD_BYTES-1:0] r_word;
   logic [IDX_W-1:0]        r_idx;
   logic [CSUM_W-1:0]       r_csum;

   assign o_word      = {r_word[8*WORD_BYTES-9:0], i_byte};
   assign o_word_last = i_byte_en && (r_idx == IDX_W'(WORD_BYTES - 1));
   assign o_csum      = r_csum;

   // Shift bytes in MSB first, track byte position and accumulate checksum.
   always_ff @(posedge clk) begin
      if (rst_n || i_clear) begin
         r_word <= '0;
         r_idx  <= '0;
         r_csum <= '0;
      end else if (i_byte_en) begin
         r_word <= o_word;
         r_idx  <= o_word_last ? '0 : r_idx + IDX_W'(1);
         r_csum <= r_csum + CSUM_W'(i_byte);
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a counted, checksummed byte image into memory words
// and holds the core in reset until the image has been verified.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int MAX_WORDS      = DEF_MAX_WORDS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       word_cnt
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [15:0]         r_count;
   logic [15:0]         r_word_cnt;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic                r_mem_we;
   logic                r_cpu_rst;
   logic                r_load_done;
   logic                r_load_err;
   logic [TMO_W-1:0]    r_tmo;

   logic                w_xfer;
   logic                w_active;
   logic                w_timeout;
   logic [15:0]         w_hdr_n;
   logic                w_bad_count;
   logic                w_restart;
   logic                w_byte_en;
   logic                w_asm_clear;
   logic                w_word_last;
   logic                w_last_word;
   logic [31:0]         w_word;
   logic [CSUM_W-1:0]   w_csum;

   assign w_xfer      = rx_valid && rx_ready;
   assign w_active    = (r_state == HDR_LO) || (r_state == DATA) || (r_state == CSUM);
   // Idle count reaches the limit on this cycle if nothing arrives now.
   assign w_timeout   = w_active && !w_xfer && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
   assign w_hdr_n     = {r_count[15:8], rx_data};
   assign w_bad_count = (w_hdr_n == 16'd0) || (w_hdr_n > 16'(MAX_WORDS));
   assign w_restart   = start && ((r_state == DONE) || (r_state == ERROR));
   assign w_byte_en   = w_xfer && (r_state == DATA);
   // The assembler is held clear until payload starts, so stale partial
   // words from an aborted load can never leak into a new image.
   assign w_asm_clear = (r_state == HDR_HI) || (r_state == HDR_LO);
   assign w_last_word = w_word_last && (r_word_cnt == r_count - 16'd1);

   loader_word_asm u_word_asm (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (w_asm_clear),
      .i_byte_en   (w_byte_en),
      .i_byte      (rx_data),
      .o_word      (w_word),
      .o_word_last (w_word_last),
      .o_csum      (w_csum)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst_n) r_state <= HDR_HI;
      else       r_state <= w_state_next;
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         HDR_HI: if (w_xfer) w_state_next = HDR_LO;
         HDR_LO: begin
            if (w_xfer)         w_state_next = w_bad_count ? ERROR : DATA;
            else if (w_timeout) w_state_next = ERROR;
         end
         DATA: begin
            if (w_last_word)    w_state_next = CSUM;
            else if (w_timeout) w_state_next = ERROR;
         end
         CSUM: begin
            if (w_xfer)         w_state_next = (rx_data == w_csum) ? DONE : ERROR;
            else if (w_timeout) w_state_next = ERROR;
         end
         DONE, ERROR: if (start) w_state_next = HDR_HI;
         default: w_state_next = HDR_HI;
      endcase
   end

   // Stream ready is the only output decoded straight from state.
   always_comb begin
      rx_ready = 1'b0;
      unique case (r_state)
         HDR_HI, HDR_LO, DATA, CSUM: rx_ready = 1'b1;
         default:                    rx_ready = 1'b0;
      endcase
   end

   // Status flags registered from the state being entered.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_cpu_rst   <= 1'b1;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         r_cpu_rst   <= (w_state_next != DONE);
         r_load_done <= (w_state_next == DONE);
         r_load_err  <= (w_state_next == ERROR);
      end
   end

   // Header capture, memory write port, word/address counters and idle timer.
   always_ff @(posedge clk) begin
      if (rst_n || w_restart) begin
         r_count     <= '0;
         r_word_cnt  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_tmo       <= '0;
      end else begin
         r_mem_we <= 1'b0;
         if (w_active && !w_xfer) r_tmo <= r_tmo + TMO_W'(1);
         else                     r_tmo <= '0;
         if ((r_state == HDR_HI) && w_xfer) r_count[15:8] <= rx_data;
         if ((r_state == HDR_LO) && w_xfer) r_count[7:0]  <= rx_data;
         if (w_word_last) begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_word;
            r_word_cnt  <= r_word_cnt + 16'd1;
         end
         // Advance after each write, but park on the last word of the image.
         if (r_mem_we && (r_word_cnt != r_count)) r_mem_addr <= r_mem_addr + ADDR_W'(1);
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_rst   = r_cpu_rst;
   assign load_done = r_load_done;
   assign load_err  = r_load_err;
   assign word_cnt  = r_word_cnt;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the multi-cycle MIPS core and its unified instruction/data memory.
- Consumes a byte stream from a serial receiver (valid/ready), assembles big-endian 32-bit words, and writes them to consecutive memory word addresses through a dedicated write port.
- Holds the core in reset until a complete, checksum-verified image is loaded, then releases it.

Parameters:
- ADDR_W, 8, memory word-address width.
- MAX_WORDS, 256, largest legal image in words; must be ≤ 2**ADDR_W.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles allowed between bytes once a header byte has been accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-high (1 = reset), sampled on the rising edge of clk.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream data.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid & rx_ready.
- start  in  1  single-cycle pulse that restarts loading from DONE or ERROR.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- cpu_rst  out  1  reset to the core, active-high.
- load_done  out  1  image loaded and verified.
- load_err  out  1  load failed.
- word_cnt  out  16  words written so far.

Behaviour:
- Image format: count hi byte, count lo byte (N), then 4N payload bytes (MSB first per word), then 1 checksum byte.
- Checksum rule: sum mod 256 of the payload bytes only must equal the checksum byte.
- Reset values:
  - state = HDR_HI; rx_ready = 1; mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - cpu_rst = 1; load_done = 0; load_err = 0; word_cnt = 0.
  - Internal: checksum accumulator, byte index and timeout counter all cleared.
- Reset asserted mid-load: loader returns to HDR_HI on the next edge. Partial words are discarded. Memory contents already written are left as-is.
- States:
  - HDR_HI: on transfer, latch count[15:8] and go to HDR_LO.
  - HDR_LO: on transfer, latch count[7:0]. If N == 0 or N > MAX_WORDS, go to ERROR; otherwise go to DATA.
  - DATA: each transfer shifts the byte into the word register and adds it to the checksum. On the 4th byte of a word:
    - The next cycle drives mem_we = 1 with mem_wdata = the assembled word and mem_addr = the current word address.
    - word_cnt increments in that same cycle.
    - The address increments after the write.
    - After word N is written, go to CSUM.
    - rx_ready stays 1 throughout DATA, so the next word's first byte may be accepted in the same cycle as mem_we.
  - CSUM: on transfer, compare the byte with the accumulator. Match goes to DONE; mismatch goes to ERROR.
  - DONE: rx_ready = 0, load_done = 1, cpu_rst = 0. A start pulse goes to HDR_HI and clears all counters and flags; cpu_rst = 1 again on the next cycle.
  - ERROR: rx_ready = 0, load_err = 1, cpu_rst = 1. A start pulse goes to HDR_HI as above.
- Timeout:
  - The counter runs in HDR_LO, DATA and CSUM, and clears on every transfer.
  - When it reaches TIMEOUT_CYCLES with no transfer, go to ERROR.
  - HDR_HI never times out.
- mem_we is a single-cycle pulse; it is never asserted outside DATA or the cycle immediately after the final payload byte.
- start is ignored in HDR_HI, HDR_LO, DATA and CSUM.
- Simultaneous start and rst_n: rst_n wins.
- Address wrap is impossible because N ≤ MAX_WORDS ≤ 2**ADDR_W; mem_addr never exceeds N-1.
- All outputs are registered except rx_ready, which is decoded from state.

Decomposition:
- Shared package:
  - State encoding enum (HDR_HI, HDR_LO, DATA, CSUM, DONE, ERROR).
  - Constants WORD_BYTES = 4 and CSUM_W = 8.
  - Default MAX_WORDS and TIMEOUT_CYCLES.
- Sub-module loader_word_asm: byte shift register, byte index 0..3, word-complete pulse and checksum accumulator. The FSM, address counter and timeout counter stay in program_loader.

Test Plan:
- Happy path: N = 2, bytes 00 02 | 20 08 00 05 | AC 08 00 00 | checksum.
  - Checksum = (20+08+00+05+AC+08+00+00) mod 256 = 0xE1.
  - Required: mem writes 0x20080005@0 and 0xAC080000@1, word_cnt = 2, load_done = 1, cpu_rst = 0 on the cycle after the checksum transfer.
- Bad checksum: same image with checksum 0xE0.
  - Required: both words still written, load_err = 1, cpu_rst stays 1, rx_ready = 0.
- Illegal count: header 00 00, and separately header 01 01 (257 > MAX_WORDS).
  - Required: ERROR immediately after the second header byte, no mem_we ever.
- Back-to-back stream with rx_valid held high for 11 bytes (header 00 02 + 8 payload + checksum):
  - Required: exactly 2 single-cycle mem_we pulses, no byte lost, rx_ready never deasserts before CSUM completes.
- Timeout: TIMEOUT_CYCLES = 16; stall 16 cycles after the 3rd payload byte.
  - Required: load_err = 1, no mem_we for the partial word.
  - Then pulse start and send a valid N = 1 image: load_done = 1, load_err = 0.
- Reset mid-load: assert rst_n during DATA after word 0 has been written.
  - Required: next cycle state = HDR_HI, word_cnt = 0, mem_addr = 0, cpu_rst = 1.
  - A fresh image then loads from address 0.
